hazard_stall_ctrl: RTL and testbench

- Stall/flush half of pipeline hazard handling; companion to the forwarding unit, which drives the ForwardAE/ForwardBE muxes.
- Resolves the cases forwarding cannot cover:
  - load-use in Decode vs Execute (stall F/D, bubble E);
  - taken branch/jump resolved in Execute (flush D/E);
  - multi-cycle data-memory wait in Memory (freeze F..M, bubble W).
- Memory-wait FSM with timeout; raises a sticky error and halts the pipeline.
- Sits beside the 5-stage datapath; drives the enable/clear inputs of the pipeline registers.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_mem_wait_fsm.sv | 60 ++++++
 rtl/hazard_stall_ctrl.sv | 95 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_pkg;

  localparam int REG_W           = 5;
  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Tracks multi-cycle data-memory waits, requests a pipeline freeze and
// latches a sticky error when a wait runs past MEM_TIMEOUT cycles.
module hazard_mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_wait,
  output logic freeze,
  output logic mem_err
);

  localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_wait) begin
            state <= ST_WAIT;
            cnt   <= TO_W'(1);
          end
        end
        ST_WAIT: begin
          if (!mem_wait) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state   <= ST_ERR;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        // ERR is terminal until reset; counter deliberately left untouched
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Freeze must act in the same cycle the wait is seen, hence combinational
  assign freeze = (state == ST_ERR) | mem_wait;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, taken-branch and memory-wait
// handling. Optional HAZARD_PERF_EN adds stall/flush event counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RS1D,
  input  logic [REG_W-1:0] RS2D,
  input  logic [REG_W-1:0] RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
);

  logic mem_wait;
  logic lw_stall;
  logic freeze;

  assign mem_wait = MemReqM & ~MemReadyM;
  assign lw_stall = ResultSrcE0 & (RdE != '0) & ((RdE == RS1D) | (RdE == RS2D));

  hazard_mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_wait (mem_wait),
    .freeze   (freeze),
    .mem_err  (mem_err)
  );

  // Outputs are forced low while reset is held, whatever the inputs do
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // mem_err is high exactly while in ERR, so it doubles as the freeze gate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (!mem_err) begin
      if (StallF)          stall_q <= stall_q + 32'd1;
      if (FlushD | FlushE) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4).
module tb_hazard_stall_ctrl;

  localparam logic [6:0] IDLE   = 7'b0000000;
  localparam logic [6:0] LU     = 7'b1100010;
  localparam logic [6:0] BR     = 7'b0000110;
  localparam logic [6:0] LUBR   = 7'b1100110;
  localparam logic [6:0] MODE_B = 7'b1111001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  RS1D = '0, RS2D = '0, RdE = '0;
  logic        ResultSrcE0 = 1'b0, PCSrcE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [31:0] stall_cycles, flush_events;
  logic [6:0]  outs;

  int checks = 0;
  int errors = 0;
  int perfStall = 0;
  int perfFlush = 0;

  always #5 clk = ~clk;

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  hazard_stall_ctrl #(
    .MEM_TIMEOUT (4),
    .TO_W        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RS1D         (RS1D),
    .RS2D         (RS2D),
    .RdE          (RdE),
    .ResultSrcE0  (ResultSrcE0),
    .PCSrcE       (PCSrcE),
    .MemReqM      (MemReqM),
    .MemReadyM    (MemReadyM),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic ld, input logic br, input logic req, input logic rdy);
    @(negedge clk);
    RS1D = rs1; RS2D = rs2; RdE = rd;
    ResultSrcE0 = ld; PCSrcE = br; MemReqM = req; MemReadyM = rdy;
    #1;
  endtask

  // Checks the control vector and error flag, then advances the expected perf counts
  task automatic checkModes(input string tag, input logic [6:0] exp, input logic expErr);
    checkOutput(tag, {25'b0, outs}, {25'b0, exp});
    checkOutput({tag, "_err"}, {31'b0, mem_err}, {31'b0, expErr});
    if (!expErr) begin
      if (exp[6])          perfStall++;
      if (exp[2] | exp[1]) perfFlush++;
    end
  endtask

  task automatic checkPerf(input string tag);
`ifdef HAZARD_PERF_EN
    checkOutput({tag, "_stall"}, stall_cycles, perfStall);
    checkOutput({tag, "_flush"}, flush_events, perfFlush);
`else
    checkOutput({tag, "_stall_off"}, stall_cycles, 32'd0);
    checkOutput({tag, "_flush_off"}, flush_events, 32'd0);
`endif
  endtask

  task automatic doReset(input string tag);
    RS1D = 5'd3; RS2D = 5'd4; RdE = 5'd3;
    ResultSrcE0 = 1'b1; PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkOutput({tag, "_outs"}, {25'b0, outs}, 32'd0);
    checkOutput({tag, "_err"}, {31'b0, mem_err}, 32'd0);
    perfStall = 0;
    perfFlush = 0;
    RS1D = '0; RS2D = '0; RdE = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2;
    doReset("reset");
    checkPerf("perf_reset");

    // Event-count scenario: 2 load-use, 3 wait cycles, 1 branch
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 0, 0, 0); checkModes("pf_lu1", LU, 0);
    applyStimulus(5'd0, 5'd7, 5'd7, 1, 0, 0, 0); checkModes("pf_lu2", LU, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("pf_w1", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("pf_w2", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("pf_w3", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 1); checkModes("pf_ready", IDLE, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 1, 0, 0); checkModes("pf_br", BR, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); checkModes("pf_idle", IDLE, 0);
`ifdef HAZARD_PERF_EN
    checkOutput("perf_stall_5", stall_cycles, 32'd5);
    checkOutput("perf_flush_3", flush_events, 32'd3);
`else
    checkOutput("perf_stall_0", stall_cycles, 32'd0);
    checkOutput("perf_flush_0", flush_events, 32'd0);
`endif

    // Load-use and branch combinations in RUN
    applyStimulus(5'd5, 5'd1, 5'd5, 1, 0, 0, 0); checkModes("lu_rs1", LU, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1, 0, 0, 0); checkModes("lu_rd0", IDLE, 0);
    applyStimulus(5'd6, 5'd7, 5'd5, 1, 0, 0, 0); checkModes("lu_nomatch", IDLE, 0);
    applyStimulus(5'd5, 5'd1, 5'd5, 0, 0, 0, 0); checkModes("nonload_match", IDLE, 0);
    applyStimulus(5'd1, 5'd9, 5'd9, 1, 0, 0, 0); checkModes("lu_rs2", LU, 0);
    applyStimulus(5'd0, 5'd0, 5'd3, 0, 1, 0, 0); checkModes("branch", BR, 0);
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 1, 0, 0); checkModes("lu_branch", LUBR, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 1); checkModes("single_access", IDLE, 0);
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 0, 0, 0); checkModes("after_single", LU, 0);

    // Three-cycle wait with hazards present but ignored
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 1, 1, 0); checkModes("wait1", MODE_B, 0);
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 1, 1, 0); checkModes("wait2", MODE_B, 0);
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 1, 1, 0); checkModes("wait3", MODE_B, 0);
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 1, 1, 1); checkModes("wait_done", LUBR, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); checkModes("wait_idle", IDLE, 0);
    checkPerf("perf_mid");

    // Timeout: fourth consecutive wait edge enters ERR
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("to1", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("to2", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("to3", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("to4", MODE_B, 0);
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 1, 1, 1); checkModes("err_ready", MODE_B, 1);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); checkModes("err_idle", MODE_B, 1);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 1, 0, 0); checkModes("err_branch", MODE_B, 1);
    checkPerf("perf_err");

    doReset("err_clear");
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 1, 0, 0); checkModes("post_err_br", BR, 0);

    // Asynchronous reset while waiting
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("rw1", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("rw2", MODE_B, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async_outs", {25'b0, outs}, 32'd0);
    checkOutput("rst_async_err", {31'b0, mem_err}, 32'd0);
    perfStall = 0;
    perfFlush = 0;
    MemReqM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(5'd5, 5'd0, 5'd5, 1, 0, 0, 0); checkModes("rw_run", LU, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("rw_w1", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("rw_w2", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); checkModes("rw_w3", MODE_B, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); checkModes("rw_done", IDLE, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); checkModes("rw_idle", IDLE, 0);
    checkPerf("perf_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
